// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_pkg
//  Description : Shared types and constants for the scan chain sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

   // Largest chain the sequencer is intended to drive
   localparam int c_MAX_CHAIN_LEN = 64;

   // Sequencer phases; IDLE is the only state in which busy is low
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SHIFT_IN  = 3'd1,
      CAPTURE   = 3'd2,
      SHIFT_OUT = 3'd3,
      DONE      = 3'd4
   } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/scan_chain_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : scan_chain_ctrl_if
//  Description : Host / chain side signals of the scan chain sequencer.
//                The slave modport is the sequencer's view; the master
//                modport is the host plus the chain's serial output.
//  Revision    : 1.0 - initial release
// ============================================================================
interface scan_chain_ctrl_if #(
   parameter int CHAIN_LEN = 8
);
   logic                 start;
   logic [CHAIN_LEN-1:0] pattern;
   logic [CHAIN_LEN-1:0] expected;
   logic                 scan_out;
   logic                 mode;
   logic                 scan_in;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [CHAIN_LEN-1:0] response;

   modport master (
      output start, pattern, expected, scan_out,
      input  mode, scan_in, busy, done, pass, response
   );

   modport slave (
      input  start, pattern, expected, scan_out,
      output mode, scan_in, busy, done, pass, response
   );
endinterface
`default_nettype wire

// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scan_chain_ctrl
//  Description : Scan test sequencer for a single chain. Serially loads a
//                stimulus (MSB first), pulses one functional capture cycle,
//                unloads the response and compares it with the expected
//                vector. Every output is a register.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_chain_ctrl
   import scan_pkg::*;
#(
   parameter int CHAIN_LEN = 8
) (
   input  wire logic         clk,
   input  wire logic         rst,
   scan_chain_ctrl_if.slave  bus
);

   localparam int                c_CNT_W    = $clog2(CHAIN_LEN + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(CHAIN_LEN - 1);

   scan_state_t          r_state,   w_state;
   logic [c_CNT_W-1:0]   r_cnt,     w_cnt;
   logic [CHAIN_LEN-1:0] r_sr,      w_sr;
   logic [CHAIN_LEN-1:0] r_exp,     w_exp;
   logic [CHAIN_LEN-1:0] r_resp,    w_resp;
   logic                 r_mode,    w_mode;
   logic                 r_scan_in, w_scan_in;
   logic                 r_busy,    w_busy;
   logic                 r_done,    w_done;
   logic                 r_pass,    w_pass;

   // Response with the pre-edge scan_out appended at bit 0
   logic [CHAIN_LEN-1:0] w_resp_shift;
   assign w_resp_shift = (r_resp << 1) | CHAIN_LEN'(bus.scan_out);

   // Next-state and next-output decode; r_sr holds the bits still to be sent,
   // already aligned so that its MSB is the next scan_in value
   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt;
      w_sr      = r_sr;
      w_exp     = r_exp;
      w_resp    = r_resp;
      w_mode    = r_mode;
      w_scan_in = r_scan_in;
      w_pass    = r_pass;
      w_done    = 1'b0;

      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state   = SHIFT_IN;
               w_cnt     = c_CNT_LOAD;
               w_sr      = bus.pattern << 1;
               w_exp     = bus.expected;
               w_resp    = '0;
               w_pass    = 1'b0;
               w_mode    = 1'b1;
               w_scan_in = bus.pattern[CHAIN_LEN-1];
            end
         end
         SHIFT_IN: begin
            if (r_cnt == '0) begin
               w_state   = CAPTURE;
               w_mode    = 1'b0;
               w_scan_in = 1'b0;
            end else begin
               w_cnt     = r_cnt - 1'b1;
               w_sr      = r_sr << 1;
               w_scan_in = r_sr[CHAIN_LEN-1];
            end
         end
         CAPTURE: begin
            w_state = SHIFT_OUT;
            w_mode  = 1'b1;
            w_cnt   = c_CNT_LOAD;
         end
         SHIFT_OUT: begin
            w_resp = w_resp_shift;
            if (r_cnt == '0) begin
               w_state = DONE;
               w_pass  = (w_resp_shift == r_exp);
               w_mode  = 1'b0;
               w_done  = 1'b1;
            end else begin
               w_cnt = r_cnt - 1'b1;
            end
         end
         DONE: begin
            w_state = IDLE;
         end
         default: begin
            w_state   = IDLE;
            w_mode    = 1'b0;
            w_scan_in = 1'b0;
         end
      endcase

      w_busy = (w_state != IDLE);
   end

   // State and output registers, cleared asynchronously together with the chain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_sr      <= '0;
         r_exp     <= '0;
         r_resp    <= '0;
         r_mode    <= 1'b0;
         r_scan_in <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_sr      <= w_sr;
         r_exp     <= w_exp;
         r_resp    <= w_resp;
         r_mode    <= w_mode;
         r_scan_in <= w_scan_in;
         r_busy    <= w_busy;
         r_done    <= w_done;
         r_pass    <= w_pass;
      end
   end

   assign bus.mode     = r_mode;
   assign bus.scan_in  = r_scan_in;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.pass     = r_pass;
   assign bus.response = r_resp;

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_chain_ctrl
//  Description : Directed self-checking bench for scan_chain_ctrl with an
//                8-flop and a 1-flop chain model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_chain_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   scan_chain_ctrl_if #(.CHAIN_LEN(8)) bus8 ();
   scan_chain_ctrl_if #(.CHAIN_LEN(1)) bus1 ();

   scan_chain_ctrl #(.CHAIN_LEN(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
   scan_chain_ctrl #(.CHAIN_LEN(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   // Chain models: shift when mode=1, else each flop loads q ^ inv (hold or invert)
   logic [7:0] r_q8;
   logic [7:0] inv8 = 8'h00;
   logic       r_q1;
   logic       inv1 = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst)           r_q8 <= 8'h00;
      else if (bus8.mode) r_q8 <= {r_q8[6:0], bus8.scan_in};
      else                r_q8 <= r_q8 ^ inv8;
   end

   always @(posedge clk or negedge rst) begin
      if (!rst)           r_q1 <= 1'b0;
      else if (bus1.mode) r_q1 <= bus1.scan_in;
      else                r_q1 <= r_q1 ^ inv1;
   end

   assign bus8.scan_out = r_q8[7];
   assign bus1.scan_out = r_q1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Per-run observations of the 8-flop sequencer
   logic [17:0] v_mode;
   logic [7:0]  v_si_in;
   logic        v_si_out;
   int          n_busy, n_done, done_at;
   logic [7:0]  resp_at_done;
   logic        pass_at_done;

   // Start one test and watch cycles 1..20 after the accepting edge
   task automatic run8(input logic [7:0] pat, input logic [7:0] exp);
      @(negedge clk);
      bus8.pattern  = pat;
      bus8.expected = exp;
      bus8.start    = 1'b1;
      @(posedge clk);
      #1 bus8.start = 1'b0;
      v_mode = '0; v_si_in = '0; v_si_out = 1'b0;
      n_busy = 0; n_done = 0; done_at = -1;
      resp_at_done = '0; pass_at_done = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         if (c <= 18)            v_mode  = {v_mode[16:0], bus8.mode};
         if (c <= 8)             v_si_in = {v_si_in[6:0], bus8.scan_in};
         if (c >= 10 && c <= 17) v_si_out = v_si_out | bus8.scan_in;
         if (bus8.busy) n_busy++;
         if (bus8.done) begin
            n_done++;
            if (done_at < 0) begin
               done_at      = c;
               resp_at_done = bus8.response;
               pass_at_done = bus8.pass;
            end
         end
      end
   endtask

   int          done1_at;
   logic        pass1;
   logic        resp1;

   task automatic run1(input logic pat, input logic exp);
      @(negedge clk);
      bus1.pattern  = pat;
      bus1.expected = exp;
      bus1.start    = 1'b1;
      @(posedge clk);
      #1 bus1.start = 1'b0;
      done1_at = -1; pass1 = 1'b0; resp1 = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         if (bus1.done && done1_at < 0) begin
            done1_at = c;
            pass1    = bus1.pass;
            resp1    = bus1.response;
         end
      end
   endtask

   int   n_rise, n_done4, prev_busy, busy19, busy20, done4_1st, done4_2nd;
   logic [7:0] resp4_a, resp4_b;
   logic       pass4_a, pass4_b;

   initial begin
      bus8.start = 1'b0; bus8.pattern = '0; bus8.expected = '0;
      bus1.start = 1'b0; bus1.pattern = '0; bus1.expected = '0;

      // Reset values while rst is held low
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mode",     bus8.mode,     0);
      chk("rst_scan_in",  bus8.scan_in,  0);
      chk("rst_busy",     bus8.busy,     0);
      chk("rst_done",     bus8.done,     0);
      chk("rst_pass",     bus8.pass,     0);
      chk("rst_response", bus8.response, 0);
      @(negedge clk) rst = 1'b1;
      repeat (2) @(posedge clk);

      // 1: hold chain, A5 in -> A5 out, pass; also waveform of mode/scan_in
      inv8 = 8'h00;
      run8(8'hA5, 8'hA5);
      chk("t1_response",   resp_at_done, 8'hA5);
      chk("t1_pass",       pass_at_done, 1);
      chk("t1_done_at",    done_at, 18);
      chk("t1_done_cnt",   n_done, 1);
      chk("t1_busy_cnt",   n_busy, 18);
      chk("t1_mode_wave",  v_mode, 18'b111111110111111110);
      chk("t1_scanin_seq", v_si_in, 8'b10100101);
      chk("t1_scanin_out", v_si_out, 0);
      chk("t1_mode_idle",  bus8.mode, 0);
      chk("t1_resp_held",  bus8.response, 8'hA5);

      // 2: inverting chain, A5 in -> 5A out, fail
      inv8 = 8'hFF;
      run8(8'hA5, 8'hA5);
      chk("t2_response",  resp_at_done, 8'h5A);
      chk("t2_pass",      pass_at_done, 0);
      chk("t2_done_cnt",  n_done, 1);
      chk("t2_done_at",   done_at, 18);
      chk("t2_mode_wave", v_mode, 18'b111111110111111110);

      // 4: start held for 38 edges -> accepts at E0 and E19 only
      inv8 = 8'h00;
      @(negedge clk);
      bus8.pattern = 8'hA5; bus8.expected = 8'hA5; bus8.start = 1'b1;
      n_rise = 0; n_done4 = 0; prev_busy = 0; busy19 = -1; busy20 = -1;
      done4_1st = -1; done4_2nd = -1;
      resp4_a = '0; resp4_b = '0; pass4_a = 1'b0; pass4_b = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (bus8.busy && prev_busy == 0) n_rise++;
         prev_busy = int'(bus8.busy);
         if (c == 19) busy19 = int'(bus8.busy);
         if (c == 20) busy20 = int'(bus8.busy);
         if (bus8.done) begin
            n_done4++;
            if (done4_1st < 0) begin
               done4_1st = c; resp4_a = bus8.response; pass4_a = bus8.pass;
            end else begin
               done4_2nd = c; resp4_b = bus8.response; pass4_b = bus8.pass;
            end
         end
         if (c == 5) begin
            bus8.pattern = 8'h3C; bus8.expected = 8'h3C;
         end
         if (c == 38) bus8.start = 1'b0;
      end
      chk("t4_accepts",    n_rise, 2);
      chk("t4_done_cnt",   n_done4, 2);
      chk("t4_busy_c19",   busy19, 0);
      chk("t4_busy_c20",   busy20, 1);
      chk("t4_done_1st",   done4_1st, 18);
      chk("t4_done_2nd",   done4_2nd, 37);
      chk("t4_resp_a",     resp4_a, 8'hA5);
      chk("t4_pass_a",     pass4_a, 1);
      chk("t4_resp_b",     resp4_b, 8'h3C);
      chk("t4_pass_b",     pass4_b, 1);

      // 5: async reset during SHIFT_IN cycle 5
      @(negedge clk);
      bus8.pattern = 8'hA5; bus8.expected = 8'hA5; bus8.start = 1'b1;
      @(posedge clk);
      #1 bus8.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("t5_mode_pre", bus8.mode, 1);
      chk("t5_busy_pre", bus8.busy, 1);
      #2 rst = 1'b0;
      #1;
      chk("t5_mode",     bus8.mode,     0);
      chk("t5_scan_in",  bus8.scan_in,  0);
      chk("t5_busy",     bus8.busy,     0);
      chk("t5_pass",     bus8.pass,     0);
      chk("t5_response", bus8.response, 0);
      chk("t5_done",     bus8.done,     0);
      #2 rst = 1'b1;
      run8(8'h3C, 8'h3C);
      chk("t5_after_resp", resp_at_done, 8'h3C);
      chk("t5_after_pass", pass_at_done, 1);
      chk("t5_after_done", done_at, 18);

      // 6: single-flop chain
      inv1 = 1'b0;
      run1(1'b1, 1'b1);
      chk("t6_pass1",    pass1, 1);
      chk("t6_resp1",    resp1, 1);
      chk("t6_done_at1", done1_at, 4);
      run1(1'b1, 1'b0);
      chk("t6_pass0",    pass1, 0);
      chk("t6_done_at0", done1_at, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
Test sequencer for one scan chain built from scan_dff cells.
- On start it serially loads a stimulus pattern, pulses one functional capture cycle, then unloads the captured response.
- Compares the unloaded response against an expected vector and reports pass/fail.
- Sits between the test/BIST host logic and the chain's shared mode and scan_in nets.

Parameters:
CHAIN_LEN, 8, number of scan flops in the chain (legal range 1..64)

Ports:
clk        input   1          system clock; chain flops use the same clock
rst        input   1          reset; asynchronous, active-low; the chain flops share it
start      input   1          request to run one test; accepted only in IDLE
pattern    input   CHAIN_LEN  stimulus; bit k is the value to load into chain flop k; sampled when start is accepted
expected   input   CHAIN_LEN  expected captured value of flop k in bit k; sampled when start is accepted
scan_out   input   1          q of chain flop CHAIN_LEN-1, the last flop
mode       output  1          scan enable to every chain flop: 1 = shift, 0 = functional capture
scan_in    output  1          serial data into chain flop 0
busy       output  1          high whenever state != IDLE
done       output  1          one-cycle pulse when the test completes
pass       output  1          1 if response == expected; valid from done, held until the next accepted start
response   output  CHAIN_LEN  unloaded captured data; bit k = flop k; held until the next accepted start

Behaviour:
- Chain topology: flop 0 is fed by scan_in; flop i feeds flop i+1; flop CHAIN_LEN-1 drives scan_out.
- Reset (async, rst=0): state=IDLE; mode=0, scan_in=0, busy=0, done=0, pass=0, response=0, counter=0.
- All outputs are registered. busy is decoded from state, so it is glitch-free.
- States are IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE. Edges are numbered from E0, the edge that accepts start.
- IDLE:
  - If start=1 at E0: latch pattern into a shift register and latch expected.
  - Clear response and pass.
  - Go to SHIFT_IN with mode=1 and scan_in=pattern[CHAIN_LEN-1].
- SHIFT_IN:
  - Chain shift edges are E1..E_N (N=CHAIN_LEN).
  - Bits are presented MSB first: scan_in carries pattern[N-1], then pattern[N-2], ... then pattern[0].
  - After E_N, flop k holds pattern[k]. Then mode=0, scan_in=0, go to CAPTURE.
- CAPTURE:
  - Exactly one edge, E_{N+1}, with mode=0; the chain captures d.
  - Then mode=1, go to SHIFT_OUT.
- SHIFT_OUT:
  - Edges E_{N+2}..E_{2N+1}, with mode=1 and scan_in=0.
  - At each edge, sample the pre-edge scan_out: response <= {response[N-2:0], scan_out}.
  - After E_{2N+1}, response[k] = captured flop k.
  - At E_{2N+1}:
    - pass <= ({response[N-2:0], scan_out} == expected_q);
    - mode <= 0;
    - go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE at E_{2N+2}.
  - A start sampled at E_{2N+2} (IDLE only from the following cycle) is ignored.
- mode profile per test: exactly N cycles high, 1 low, N high. mode is 0 in IDLE and DONE.
- start while busy (including DONE) is ignored, with no side effects. pattern/expected changes while busy are ignored.
- Latency: done is high in the cycle after E_{2N+1}, i.e. 2N+2 cycles after the start cycle.
- Shift counter:
  - Width $clog2(CHAIN_LEN+1); loaded with N-1 at each phase entry; the phase ends when it reaches 0.
  - N=1 is supported: single-cycle shift phases.
- Reset mid-operation: immediate return to the reset values above. The chain contents are cleared by the same rst. No partial done/pass.

Decomposition:
- Package scan_pkg:
  - typedef enum logic [2:0] scan_state_t {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE};
  - localparam for max CHAIN_LEN (64).
- RTL is a single module; no sub-module is needed.
- The bench builds a scan_chain model of CHAIN_LEN scan_dff instances with a selectable d function per flop.

Test Plan:
1. N=8, d_k = q_k (hold), pattern=8'hA5, expected=8'hA5 -> response=8'hA5, pass=1, done 18 cycles after the start cycle, busy high for 18 cycles.
2. N=8, d_k = ~q_k, pattern=8'hA5, expected=8'hA5 -> response=8'h5A, pass=0, done pulse exactly 1 cycle.
3. Waveform check, pattern=8'hA5:
   - scan_in = 1,0,1,0,0,1,0,1 over the 8 SHIFT_IN cycles.
   - mode = 8×1, 1×0, 8×1, then 0.
   - scan_in=0 during SHIFT_OUT.
4. start held high continuously for 40 cycles -> two tests run back-to-back.
   - No start accepted while busy.
   - Second accept occurs in the first IDLE cycle after DONE.
   - pattern change mid-test has no effect.
5. rst pulsed low during cycle 5 of SHIFT_IN -> mode=0, scan_in=0, busy=0, pass=0, response=0 asynchronously. A subsequent start with pattern=8'h3C (hold) gives response=8'h3C, pass=1.
6. CHAIN_LEN=1, hold chain:
   - pattern=1, expected=1 -> pass=1, done 4 cycles after start.
   - Then pattern=1, expected=0 -> pass=0.
